int_vec_ctrl: RTL and testbench

Parametrised, clocked interrupt controller for the hardwired-control CPU; replaces the single-pulse, single-enable interrupt logic with NCH prioritised, maskable, vectored request channels and a nesting-level stack. It sits beside the beat-driven control unit: the control unit reports instruction boundaries, EI/DI/IRET execution, and vector-load acknowledge; this block raises INT and supplies the vector for the hardware interrupt cycle.

---
 rtl/int_vec_pkg.sv | 25 ++
 rtl/int_vec_ctrl_if.sv | 41 ++++
 rtl/int_sync_edge.sv | 34 +++
 rtl/int_vec_ctrl.sv | 165 ++++++++++++++++
 tb/tb_int_vec_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/int_vec_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// Build option INT_NEST_EN (see int_vec_ctrl) does not affect this package.
package int_vec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StTake
  } state_e;

  // Bit width needed to hold values 0..n-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int vec_of(input int base, input int stride, input int idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/int_vec_ctrl_if.sv
// Request/strobe inputs and status outputs of int_vec_ctrl, bundled as one interface.
// slave = the controller, master = the control unit side.
interface int_vec_ctrl_if #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned NEST_DEPTH = 2
) ();
  import int_vec_pkg::*;

  localparam int unsigned IW = clog2(NCH);
  localparam int unsigned LW = clog2(NCH + 1);
  localparam int unsigned DW = clog2(NEST_DEPTH + 1);

  logic [NCH-1:0]   PULSE;
  logic             INS_END;
  logic             EI;
  logic             DI;
  logic             IRET;
  logic             ACK;
  logic             MASK_WE;
  logic [NCH-1:0]   MASK_D;
  logic             INT;
  logic [VEC_W-1:0] VEC;
  logic [IW-1:0]    IID;
  logic             IEN;
  logic [NCH-1:0]   PEND;
  logic [LW-1:0]    LEVEL;
  logic [DW-1:0]    DEPTH;
  logic             ERR;

  modport slave (
    input  PULSE, INS_END, EI, DI, IRET, ACK, MASK_WE, MASK_D,
    output INT, VEC, IID, IEN, PEND, LEVEL, DEPTH, ERR
  );

  modport master (
    output PULSE, INS_END, EI, DI, IRET, ACK, MASK_WE, MASK_D,
    input  INT, VEC, IID, IEN, PEND, LEVEL, DEPTH, ERR
  );

endinterface

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw request line.
// edge_o is a one-cycle pulse, high the cycle after the second sync flop rises.
module int_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = async_i;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign edge_o = s2_q & ~prev_q;

endmodule

// File: rtl/int_vec_ctrl.sv
// Prioritised, maskable, vectored interrupt controller with a priority-level stack.
// Define INT_NEST_EN to allow NEST_DEPTH nested handlers; otherwise one level only.
module int_vec_ctrl #(
  parameter int unsigned      NCH        = 4,
  parameter int unsigned      VEC_W      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE   = 8'h80,
  parameter int unsigned      VEC_STRIDE = 4,
  parameter int unsigned      NEST_DEPTH = 2
) (
  input logic            T3,
  input logic            CLR,
  int_vec_ctrl_if.slave  bus
);
  import int_vec_pkg::*;

  localparam int unsigned IW = clog2(NCH);
  localparam int unsigned LW = clog2(NCH + 1);
  localparam int unsigned DW = clog2(NEST_DEPTH + 1);
`ifdef INT_NEST_EN
  localparam int unsigned NestEff = NEST_DEPTH;
`else
  localparam int unsigned NestEff = 1;
`endif
  // Sized to cover every DEPTH code so indexing never goes out of range.
  localparam int unsigned StackN = 1 << DW;

  state_e           state_q, state_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [IW-1:0]    iid_q, iid_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ien_q, ien_d;
  logic             err_q, err_d;
  logic [LW-1:0]    stack_q [StackN];
  logic [LW-1:0]    stack_d [StackN];

  logic [NCH-1:0]   edge_det;
  logic [NCH-1:0]   elig;
  logic [IW-1:0]    winner;
  logic             take_ok;
  logic             take;

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    int_sync_edge u_sync (
      .clk_i  (T3),
      .rst_i  (CLR),
      .async_i(bus.PULSE[g]),
      .edge_o (edge_det[g])
    );
  end

  // Only channels strictly more urgent than the level in service may interrupt.
  always_comb begin
    elig   = '0;
    winner = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      elig[i] = pend_q[i] & ~mask_q[i] & (LW'(i) < level_q);
    end
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (elig[i]) winner = IW'(i);
    end
  end

  assign take_ok = ien_q & (depth_q < DW'(NestEff));

  always_comb begin
    state_d = state_q;
    iid_d   = iid_q;
    vec_d   = vec_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (take_ok && (elig != '0)) state_d = StArm;
      end
      StArm: begin
        if (!take_ok || (elig == '0)) begin
          state_d = StIdle;
        end else if (bus.INS_END) begin
          state_d = StTake;
          iid_d   = winner;
          vec_d   = VEC_W'(vec_of(int'(VEC_BASE), int'(VEC_STRIDE), int'(winner)));
        end
      end
      StTake: begin
        if (bus.ACK) begin
          state_d = StIdle;
          take    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // A new edge wins over the clear of the same channel.
    pend_d  = (pend_q & ~(take ? (NCH'(1) << iid_q) : '0)) | edge_det;
    mask_d  = bus.MASK_WE ? bus.MASK_D : mask_q;
    ien_d   = ien_q;
    err_d   = err_q;
    level_d = level_q;
    depth_d = depth_q;
    stack_d = stack_q;

    if (take) begin
      ien_d = 1'b0;
    end else if (bus.DI) begin
      ien_d = 1'b0;
    end else if (bus.EI) begin
      ien_d = 1'b1;
    end else if (bus.IRET && (depth_q != '0)) begin
      ien_d = 1'b1;
    end

    if (take) begin
      stack_d[depth_q] = level_q;
      level_d          = LW'(iid_q);
      depth_d          = depth_q + 1'b1;
    end else if (bus.IRET) begin
      if (depth_q != '0) begin
        level_d = stack_q[depth_q - 1'b1];
        depth_d = depth_q - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      state_q <= StIdle;
      pend_q  <= '0;
      mask_q  <= '0;
      iid_q   <= '0;
      vec_q   <= VEC_BASE;
      level_q <= LW'(NCH);
      depth_q <= '0;
      ien_q   <= 1'b0;
      err_q   <= 1'b0;
      stack_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      iid_q   <= iid_d;
      vec_q   <= vec_d;
      level_q <= level_d;
      depth_q <= depth_d;
      ien_q   <= ien_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign bus.INT   = (state_q == StTake);
  assign bus.VEC   = vec_q;
  assign bus.IID   = iid_q;
  assign bus.IEN   = ien_q;
  assign bus.PEND  = pend_q;
  assign bus.LEVEL = level_q;
  assign bus.DEPTH = depth_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_int_vec_ctrl.sv
// Directed bench for int_vec_ctrl (NCH=4, base 8'h80, stride 4); the nesting
// scenario follows INT_NEST_EN, the rest is common to both builds.
module tb_int_vec_ctrl;

  logic T3;
  logic CLR;
  int   checks;
  int   failures;

  int_vec_ctrl_if #(.NCH(4), .VEC_W(8), .NEST_DEPTH(2)) bus ();

  int_vec_ctrl #(
    .NCH       (4),
    .VEC_W     (8),
    .VEC_BASE  (8'h80),
    .VEC_STRIDE(4),
    .NEST_DEPTH(2)
  ) dut (
    .T3 (T3),
    .CLR(CLR),
    .bus(bus)
  );

  always #5 T3 = ~T3;

  task automatic tick();
    @(posedge T3);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request held for two periods; PEND is set on the third edge.
  task automatic pulse_ch(input logic [3:0] m);
    bus.PULSE = m;
    tick();
    tick();
    bus.PULSE = '0;
    tick();
  endtask

  task automatic do_ei();
    bus.EI = 1'b1; tick(); bus.EI = 1'b0;
  endtask

  task automatic do_iret();
    bus.IRET = 1'b1; tick(); bus.IRET = 1'b0;
  endtask

  task automatic do_ins_end();
    bus.INS_END = 1'b1; tick(); bus.INS_END = 1'b0;
  endtask

  task automatic do_ack();
    bus.ACK = 1'b1; tick(); bus.ACK = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    T3          = 1'b0;
    CLR         = 1'b1;
    bus.PULSE   = '0;
    bus.INS_END = 1'b0;
    bus.EI      = 1'b0;
    bus.DI      = 1'b0;
    bus.IRET    = 1'b0;
    bus.ACK     = 1'b0;
    bus.MASK_WE = 1'b0;
    bus.MASK_D  = '0;
    tick();
    tick();
    CLR = 1'b0;
    tick();

    check("rst_int",   32'(bus.INT),   0);
    check("rst_vec",   32'(bus.VEC),   32'h80);
    check("rst_iid",   32'(bus.IID),   0);
    check("rst_ien",   32'(bus.IEN),   0);
    check("rst_pend",  32'(bus.PEND),  0);
    check("rst_level", 32'(bus.LEVEL), 4);
    check("rst_depth", 32'(bus.DEPTH), 0);
    check("rst_err",   32'(bus.ERR),   0);

    // Single request on channel 2.
    do_ei();
    check("a_ien", 32'(bus.IEN), 1);
    pulse_ch(4'b0100);
    check("a_pend", 32'(bus.PEND), 32'b0100);
    tick();
    check("a_arm_noint", 32'(bus.INT), 0);
    do_ins_end();
    check("a_int", 32'(bus.INT), 1);
    check("a_vec", 32'(bus.VEC), 32'h88);
    check("a_iid", 32'(bus.IID), 2);
    do_ack();
    check("a_ack_int",   32'(bus.INT),   0);
    check("a_ack_pend",  32'(bus.PEND),  0);
    check("a_ack_level", 32'(bus.LEVEL), 2);
    check("a_ack_ien",   32'(bus.IEN),   0);
    check("a_ack_depth", 32'(bus.DEPTH), 1);
    do_iret();
    check("a_iret_level", 32'(bus.LEVEL), 4);
    check("a_iret_depth", 32'(bus.DEPTH), 0);
    check("a_iret_ien",   32'(bus.IEN),   1);

    // Simultaneous channels 1 and 3: priority, then the loser after IRET.
    do_ei();
    pulse_ch(4'b1010);
    check("b_pend", 32'(bus.PEND), 32'b1010);
    tick();
    do_ins_end();
    check("b_int", 32'(bus.INT), 1);
    check("b_iid", 32'(bus.IID), 1);
    check("b_vec", 32'(bus.VEC), 32'h84);
    do_ack();
    check("b_ack_pend",  32'(bus.PEND),  32'b1000);
    check("b_ack_level", 32'(bus.LEVEL), 1);
    tick();
    check("b_hold_noint", 32'(bus.INT), 0);
    do_iret();
    check("b_iret_level", 32'(bus.LEVEL), 4);
    tick();
    check("b_arm3_noint", 32'(bus.INT), 0);
    do_ins_end();
    check("b3_int", 32'(bus.INT), 1);
    check("b3_iid", 32'(bus.IID), 3);
    check("b3_vec", 32'(bus.VEC), 32'h8c);
    do_ack();
    check("b3_ack_pend",  32'(bus.PEND),  0);
    check("b3_ack_level", 32'(bus.LEVEL), 3);
    do_iret();
    check("b3_iret_depth", 32'(bus.DEPTH), 0);

    // Nesting: inside the channel 2 handler.
    pulse_ch(4'b0100);
    tick();
    do_ins_end();
    do_ack();
    check("c_level", 32'(bus.LEVEL), 2);
    do_ei();
`ifdef INT_NEST_EN
    pulse_ch(4'b1000);
    do_ins_end();
    check("c_low_noint", 32'(bus.INT),  0);
    check("c_low_pend",  32'(bus.PEND), 32'b1000);
    pulse_ch(4'b0001);
    tick();
    do_ins_end();
    check("c_hi_int", 32'(bus.INT), 1);
    check("c_hi_iid", 32'(bus.IID), 0);
    check("c_hi_vec", 32'(bus.VEC), 32'h80);
    do_ack();
    check("c_depth2", 32'(bus.DEPTH), 2);
    check("c_level0", 32'(bus.LEVEL), 0);
    check("c_pend3",  32'(bus.PEND),  32'b1000);
    do_iret();
    check("c_iret1_level", 32'(bus.LEVEL), 2);
    check("c_iret1_depth", 32'(bus.DEPTH), 1);
    do_iret();
    check("c_iret2_level", 32'(bus.LEVEL), 4);
    check("c_iret2_depth", 32'(bus.DEPTH), 0);
    tick();
    do_ins_end();
    check("c_drain_iid", 32'(bus.IID), 3);
    do_ack();
    do_iret();
`else
    pulse_ch(4'b0001);
    tick();
    do_ins_end();
    check("c_nonest_noint", 32'(bus.INT),   0);
    check("c_nonest_depth", 32'(bus.DEPTH), 1);
    check("c_nonest_pend",  32'(bus.PEND),  32'b0001);
    do_iret();
    check("c_iret_level", 32'(bus.LEVEL), 4);
    tick();
    do_ins_end();
    check("c_drain_int", 32'(bus.INT), 1);
    check("c_drain_iid", 32'(bus.IID), 0);
    do_ack();
    do_iret();
`endif
    check("c_end_pend",  32'(bus.PEND),  0);
    check("c_end_depth", 32'(bus.DEPTH), 0);

    // Masked channel stays pending and is taken once unmasked.
    bus.MASK_WE = 1'b1; bus.MASK_D = 4'b0001; tick(); bus.MASK_WE = 1'b0;
    do_ei();
    pulse_ch(4'b0001);
    tick();
    do_ins_end();
    check("d_mask_noint", 32'(bus.INT),  0);
    check("d_mask_pend",  32'(bus.PEND), 32'b0001);
    bus.MASK_WE = 1'b1; bus.MASK_D = 4'b0000; tick(); bus.MASK_WE = 1'b0;
    tick();
    do_ins_end();
    check("d_unmask_int", 32'(bus.INT), 1);
    check("d_unmask_iid", 32'(bus.IID), 0);
    do_ack();
    do_iret();

    // IRET with nothing in service, then EI and DI together.
    do_iret();
    check("e_err",   32'(bus.ERR),   1);
    check("e_level", 32'(bus.LEVEL), 4);
    check("e_depth", 32'(bus.DEPTH), 0);
    check("e_ien",   32'(bus.IEN),   1);
    bus.EI = 1'b1; bus.DI = 1'b1; tick(); bus.EI = 1'b0; bus.DI = 1'b0;
    check("e_eidi_ien", 32'(bus.IEN), 0);

    // Reset during the interrupt cycle.
    do_ei();
    pulse_ch(4'b0100);
    tick();
    do_ins_end();
    check("f_int", 32'(bus.INT), 1);
    CLR = 1'b1;
    #1;
    check("f_clr_int",  32'(bus.INT),  0);
    check("f_clr_pend", 32'(bus.PEND), 0);
    check("f_clr_ien",  32'(bus.IEN),  0);
    check("f_clr_err",  32'(bus.ERR),  0);
    check("f_clr_vec",  32'(bus.VEC),  32'h80);
    tick();
    CLR = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
